matrix_alu_seq: RTL and testbench
=================================

Name: matrix_alu_seq

Overview:
Parametrised, element-serial successor to the coprocessor's matrix ALU. Executes one matrix operation per start/done handshake on an n×n sub-matrix (n ≤ DIM), computing one output element per cycle, or one multiply-accumulate per cycle for matrix multiply. Sits between the instruction decoder/register bank and the result writeback path.

Parameters:
ELEM_W, 8, signed two's-complement element width
DIM, 5, maximum matrix dimension; flat buses are DIM*DIM*ELEM_W wide, row-major, element (r,c) at bit offset (r*DIM+c)*ELEM_W
SIZE_W, $clog2(DIM+1), width of matrix_size

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  synchronous active-low reset
start  in  1  request pulse; accepted only while ready=1
opcode  in  3  001 sum, 010 sub, 011 mul, 100 opposite, 101 transpose, 110 scalar product; 000 and 111 invalid
matrix_size  in  SIZE_W  active dimension n
A_flat  in  DIM*DIM*ELEM_W  operand A
B_flat  in  DIM*DIM*ELEM_W  operand B
scalar  in  ELEM_W  signed scalar for opcode 110
ready  out  1  high in IDLE
busy  out  1  high in CALC
done  out  1  one-cycle pulse when result is valid
C_flat  out  DIM*DIM*ELEM_W  result; held stable from done until the next accepted start
overflow_flag  out  1  sticky OR of element overflows for the current operation; valid with done
error_flag  out  1  invalid opcode or n ∉ [1,DIM]; valid with done

Behaviour:
- Reset (reset_n=0 at a clock edge): state=IDLE; ready=1; busy=0; done=0; C_flat=0; overflow_flag=0; error_flag=0; all counters 0. Takes effect mid-operation; the partial result is discarded.
- FSM IDLE→CALC→DONE→IDLE.
- IDLE: on start=1, latch opcode, n, A, B, scalar; clear C_flat, overflow_flag, error_flag; reset row/col/k to 0. If error condition, go to DONE with error_flag=1 and C_flat=0. Otherwise go to CALC.
- CALC: busy=1, ready=0. start is ignored; latched operands are immune to input changes.
  - Element-wise ops (sum, sub, opposite, transpose, scalar): one element (row,col) per cycle, row-major. Transpose writes C(r,c)=A(c,r).
  - mul: accumulator width 2*ELEM_W+$clog2(DIM). Adds A(r,k)*B(k,c) per cycle for k=0..n-1. On k=n-1, writes C(r,c) and resets the accumulator.
  - Counters wrap col→0/row+1 at n-1. Leaving the last element (row=col=n-1, plus k=n-1 for mul) goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE (ready=1). start is not accepted in DONE.
- Latency from start edge to done=1:
  - Element-wise: n*n+1 cycles.
  - mul: n*n*n+1 cycles.
  - Error: 1 cycle.
- Elements with r≥n or c≥n are 0 in C_flat.
- Width rules: the result is the low ELEM_W bits (wrap). An element overflows if the exact result is outside [-2^(ELEM_W-1), 2^(ELEM_W-1)-1]:
  - sum/sub: from the ELEM_W+1 result.
  - opposite: the only overflow case is -2^(ELEM_W-1).
  - scalar: from the 2*ELEM_W product.
  - mul: from the final accumulator only.
  - transpose: never overflows.
- start asserted in the same cycle as reset_n=0: reset wins, and the request is dropped.

Optional Feature:
SATURATE_EN
- Defined: an overflowing element is clamped to 2^(ELEM_W-1)-1 or -2^(ELEM_W-1) according to the sign of the exact result. overflow_flag still asserts.
- Undefined: wrap to the low ELEM_W bits as above.
- Latency is identical in both builds.

Decomposition:
- matrix_alu_pkg holds:
  - opcode localparams OP_SUM..OP_SCALAR
  - state enum {S_IDLE,S_CALC,S_DONE}
  - function elem_idx(r,c,DIM)
- Sub-module matrix_alu_elem: combinational single-element datapath (op select, exact-width result, overflow detect, SATURATE_EN clamp). The top level owns the FSM, counters, accumulator and C_flat register.

Test Plan:
1. Reset/idle: hold reset_n=0 for 3 cycles during a mul in progress → next cycle ready=1, busy=0, done=0, C_flat=0, flags=0; no done pulse follows.
2. Sum, n=2: A=[1 2;3 4], B=[10 20;30 40] → done 5 cycles after start; C=[11 22;33 44]; remaining elements 0; overflow_flag=0.
3. Sum overflow, n=1: A=127, B=1 → C=-128 and overflow_flag=1 (with SATURATE_EN: C=127, overflow_flag=1).
4. Mul, n=3: A=[1 2 3;4 5 6;7 8 9], B=identity → done 28 cycles after start; C=A. Then A=all 50, B=all 1 → each C element=150, wrapping to -106, overflow_flag=1.
5. Transpose, n=5 (full size): A(r,c)=5r+c → C(r,c)=5c+r after 26 cycles. A start pulse and an A_flat change mid-CALC have no effect on the result.
6. Errors: opcode 000 with n=2 → done 1 cycle after start, error_flag=1, C=0. Opcode 001 with n=0 and with n=6 (SIZE_W=3) → same response. Opposite of -128 with n=1 → C=-128, overflow_flag=1.

Source files
------------

// File: rtl/matrix_alu_pkg.sv
// Shared opcodes, FSM state type and flat-bus indexing for the element-serial matrix ALU.
package matrix_alu_pkg;

   localparam logic [2:0] OP_SUM    = 3'b001;
   localparam logic [2:0] OP_SUB    = 3'b010;
   localparam logic [2:0] OP_MUL    = 3'b011;
   localparam logic [2:0] OP_OPP    = 3'b100;
   localparam logic [2:0] OP_TRANS  = 3'b101;
   localparam logic [2:0] OP_SCALAR = 3'b110;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   // Row-major element number inside a DIM x DIM flat bus.
   function automatic int elem_idx(input int r, input int c, input int dim);
      return r * dim + c;
   endfunction

endpackage

// File: rtl/matrix_alu_seq_if.sv
// Request/result bundle between the decoder/register bank (master) and the matrix ALU (slave).
interface matrix_alu_seq_if #(
   parameter int ELEM_W = 8,
   parameter int DIM    = 5,
   parameter int SIZE_W = $clog2(DIM + 1)
);
   localparam int FLAT_W = DIM * DIM * ELEM_W;

   logic                     start;
   logic [2:0]               opcode;
   logic [SIZE_W-1:0]        matrix_size;
   logic [FLAT_W-1:0]        A_flat;
   logic [FLAT_W-1:0]        B_flat;
   logic signed [ELEM_W-1:0] scalar;
   logic                     ready;
   logic                     busy;
   logic                     done;
   logic [FLAT_W-1:0]        C_flat;
   logic                     overflow_flag;
   logic                     error_flag;

   modport master (
      output start, opcode, matrix_size, A_flat, B_flat, scalar,
      input  ready, busy, done, C_flat, overflow_flag, error_flag
   );

   modport slave (
      input  start, opcode, matrix_size, A_flat, B_flat, scalar,
      output ready, busy, done, C_flat, overflow_flag, error_flag
   );
endinterface

// File: rtl/matrix_alu_elem.sv
// Combinational single-element datapath: exact result, overflow detect and narrowing.
// Build option SATURATE_EN: clamp overflowing elements instead of wrapping.
module matrix_alu_elem
   import matrix_alu_pkg::*;
#(
   parameter int ELEM_W = 8,
   parameter int ACC_W  = 19
) (
   input  logic [2:0]               op,
   input  logic signed [ELEM_W-1:0] a,
   input  logic signed [ELEM_W-1:0] b,
   input  logic signed [ELEM_W-1:0] scalar,
   input  logic signed [ACC_W-1:0]  acc,
   output logic signed [ACC_W-1:0]  acc_next,
   output logic [ELEM_W-1:0]        res,
   output logic                     ovf
);
   localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((1 << (ELEM_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

   logic signed [ACC_W-1:0] ax, bx, sx, exact;

   // Everything is evaluated exactly at accumulator width, wide enough for every op.
   always_comb begin
      ax       = {{(ACC_W-ELEM_W){a[ELEM_W-1]}}, a};
      bx       = {{(ACC_W-ELEM_W){b[ELEM_W-1]}}, b};
      sx       = {{(ACC_W-ELEM_W){scalar[ELEM_W-1]}}, scalar};
      acc_next = acc + ax * bx;
      case (op)
         OP_SUM:    exact = ax + bx;
         OP_SUB:    exact = ax - bx;
         OP_MUL:    exact = acc_next;
         OP_OPP:    exact = -ax;
         OP_TRANS:  exact = ax;
         OP_SCALAR: exact = ax * sx;
         default:   exact = '0;
      endcase
      ovf = (exact > MAX_V) || (exact < MIN_V);
      res = exact[ELEM_W-1:0];
`ifdef SATURATE_EN
      if (ovf) res = exact[ACC_W-1] ? MIN_V[ELEM_W-1:0] : MAX_V[ELEM_W-1:0];
`else
      res = exact[ELEM_W-1:0];
`endif
   end

endmodule

// File: rtl/matrix_alu_seq.sv
// Element-serial matrix ALU: FSM, row/col/k counters, MAC accumulator and result register.
// SATURATE_EN (see matrix_alu_elem) selects clamping instead of wrapping; latency is unchanged.
module matrix_alu_seq
   import matrix_alu_pkg::*;
#(
   parameter int ELEM_W = 8,
   parameter int DIM    = 5,
   parameter int SIZE_W = $clog2(DIM + 1)
) (
   input logic               clock,
   input logic               reset_n,
   matrix_alu_seq_if.slave   bus
);
   localparam int FLAT_W = DIM * DIM * ELEM_W;
   localparam int ACC_W  = 2 * ELEM_W + $clog2(DIM);

   state_t                   state;
   logic [2:0]               op_q;
   logic [SIZE_W-1:0]        n_q, row, col, k, last;
   logic [FLAT_W-1:0]        a_q, b_q, c_q;
   logic signed [ELEM_W-1:0] s_q, a_e, b_e;
   logic signed [ACC_W-1:0]  acc, acc_next;
   logic [ELEM_W-1:0]        res;
   logic                     ovf, req_err;
   logic                     ready_q, busy_q, done_q, ovf_q, err_q;
   int                       a_idx, b_idx, c_idx;

   assign last    = n_q - SIZE_W'(1);
   assign req_err = (bus.opcode == 3'b000) || (bus.opcode == 3'b111) ||
                    (bus.matrix_size == '0) || (bus.matrix_size > SIZE_W'(DIM));

   // Operand addressing: transpose reads A(c,r); mul walks A(r,k) and B(k,c).
   always_comb begin
      c_idx = elem_idx(int'(row), int'(col), DIM);
      a_idx = c_idx;
      b_idx = c_idx;
      if (op_q == OP_TRANS) begin
         a_idx = elem_idx(int'(col), int'(row), DIM);
      end else if (op_q == OP_MUL) begin
         a_idx = elem_idx(int'(row), int'(k), DIM);
         b_idx = elem_idx(int'(k), int'(col), DIM);
      end
   end

   assign a_e = a_q[a_idx*ELEM_W +: ELEM_W];
   assign b_e = b_q[b_idx*ELEM_W +: ELEM_W];

   matrix_alu_elem #(.ELEM_W(ELEM_W), .ACC_W(ACC_W)) u_elem (
      .op(op_q), .a(a_e), .b(b_e), .scalar(s_q), .acc(acc),
      .acc_next(acc_next), .res(res), .ovf(ovf)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
         c_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         op_q    <= '0;
         n_q     <= '0;
         row     <= '0;
         col     <= '0;
         k       <= '0;
         acc     <= '0;
      end else begin
         case (state)
            S_IDLE: if (bus.start) begin
               op_q    <= bus.opcode;
               n_q     <= bus.matrix_size;
               a_q     <= bus.A_flat;
               b_q     <= bus.B_flat;
               s_q     <= bus.scalar;
               c_q     <= '0;
               ovf_q   <= 1'b0;
               err_q   <= req_err;
               row     <= '0;
               col     <= '0;
               k       <= '0;
               acc     <= '0;
               ready_q <= 1'b0;
               if (req_err) begin
                  state  <= S_DONE;
                  done_q <= 1'b1;
               end else begin
                  state  <= S_CALC;
                  busy_q <= 1'b1;
               end
            end
            S_CALC: begin
               if (op_q == OP_MUL && k != last) begin
                  acc <= acc_next;
                  k   <= k + SIZE_W'(1);
               end else begin
                  // Element complete: commit it and step row-major.
                  c_q[c_idx*ELEM_W +: ELEM_W] <= res;
                  ovf_q <= ovf_q | ovf;
                  acc   <= '0;
                  k     <= '0;
                  if (col == last) begin
                     col <= '0;
                     if (row == last) begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                     end else begin
                        row <= row + SIZE_W'(1);
                     end
                  end else begin
                     col <= col + SIZE_W'(1);
                  end
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.ready         = ready_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.C_flat        = c_q;
   assign bus.overflow_flag = ovf_q;
   assign bus.error_flag    = err_q;

endmodule

// File: tb/tb_matrix_alu_seq.sv
// Randomised and directed bench for matrix_alu_seq against a plain-arithmetic matrix model.
module tb_matrix_alu_seq;
   localparam int ELEM_W = 8;
   localparam int DIM    = 5;
   localparam int SIZE_W = 3;
   localparam longint EMAX = (longint'(1) << (ELEM_W - 1)) - 1;
   localparam longint EMIN = -(longint'(1) << (ELEM_W - 1));

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   matrix_alu_seq_if #(.ELEM_W(ELEM_W), .DIM(DIM), .SIZE_W(SIZE_W)) bus ();
   matrix_alu_seq #(.ELEM_W(ELEM_W), .DIM(DIM), .SIZE_W(SIZE_W)) dut (
      .clock(clock), .reset_n(reset_n), .bus(bus)
   );

   int  vectors = 0, miscompares = 0;
   int  am [DIM][DIM];
   int  bm [DIM][DIM];
   int  exp_c [DIM][DIM];
   bit  exp_ovf, exp_err;
   int  exp_lat;

   task automatic chk(input string tag, input longint got, input longint exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int c_elem(input int r, input int c);
      logic signed [ELEM_W-1:0] e;
      e = bus.C_flat[(r*DIM+c)*ELEM_W +: ELEM_W];
      return int'(e);
   endfunction

   // Narrow an exact value to an element, reporting whether it was out of range.
   function automatic int fit(input longint x, output bit o);
      longint m;
      o = (x > EMAX) || (x < EMIN);
`ifdef SATURATE_EN
      if (x > EMAX) return int'(EMAX);
      if (x < EMIN) return int'(EMIN);
      return int'(x);
`else
      m = x & ((longint'(1) << ELEM_W) - 1);
      if (m > EMAX) m -= (longint'(1) << ELEM_W);
      return int'(m);
`endif
   endfunction

   task automatic model(input int op, input int n, input int s);
      longint x;
      bit o;
      exp_err = (op == 0) || (op == 7) || (n < 1) || (n > DIM);
      exp_ovf = 0;
      exp_lat = exp_err ? 1 : ((op == 3) ? n*n*n + 1 : n*n + 1);
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++) begin
            exp_c[r][c] = 0;
            if (!exp_err && r < n && c < n) begin
               case (op)
                  1: x = am[r][c] + bm[r][c];
                  2: x = am[r][c] - bm[r][c];
                  3: begin
                     x = 0;
                     for (int i = 0; i < n; i++) x += am[r][i] * bm[i][c];
                  end
                  4: x = -am[r][c];
                  5: x = am[c][r];
                  default: x = am[r][c] * s;
               endcase
               exp_c[r][c] = fit(x, o);
               exp_ovf |= o;
            end
         end
   endtask

   task automatic drive_mats();
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++) begin
            bus.A_flat[(r*DIM+c)*ELEM_W +: ELEM_W] = am[r][c][ELEM_W-1:0];
            bus.B_flat[(r*DIM+c)*ELEM_W +: ELEM_W] = bm[r][c][ELEM_W-1:0];
         end
   endtask

   task automatic fill(input int mode, input int v);
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++) begin
            case (mode)
               0: begin am[r][c] = $urandom_range(0, 255) - 128; bm[r][c] = $urandom_range(0, 255) - 128; end
               1: begin am[r][c] = v; bm[r][c] = v; end
               default: begin am[r][c] = 5*r + c; bm[r][c] = (r == c) ? 1 : 0; end
            endcase
         end
   endtask

   task automatic do_op(input string name, input int op, input int n, input int s, input bit disturb);
      int lat;
      model(op, n, s);
      @(negedge clock);
      bus.opcode      = op[2:0];
      bus.matrix_size = n[SIZE_W-1:0];
      bus.scalar      = s[ELEM_W-1:0];
      drive_mats();
      bus.start = 1'b1;
      @(posedge clock);
      #1 bus.start = 1'b0;
      lat = 1;
      if (!exp_err) begin
         chk({name, ".busy"}, longint'(bus.busy), 1);
         chk({name, ".ready"}, longint'(bus.ready), 0);
      end
      while (!bus.done && lat < 400) begin
         if (disturb && lat == 3) begin
            bus.start = 1'b1;
            for (int e = 0; e < DIM*DIM; e++) bus.A_flat[e*ELEM_W +: ELEM_W] = ELEM_W'($urandom);
         end
         if (disturb && lat == 4) bus.start = 1'b0;
         @(posedge clock);
         #1 lat++;
      end
      chk({name, ".latency"}, lat, exp_lat);
      chk({name, ".ovf"}, longint'(bus.overflow_flag), longint'(exp_ovf));
      chk({name, ".err"}, longint'(bus.error_flag), longint'(exp_err));
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++)
            chk($sformatf("%s.C[%0d][%0d]", name, r, c), c_elem(r, c), exp_c[r][c]);
      @(posedge clock);
      #1;
      chk({name, ".done_pulse"}, longint'(bus.done), 0);
      chk({name, ".ready_after"}, longint'(bus.ready), 1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int dcnt, op, n;
      bus.start = 1'b0; bus.opcode = '0; bus.matrix_size = '0;
      bus.A_flat = '0; bus.B_flat = '0; bus.scalar = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      chk("reset.ready", longint'(bus.ready), 1);
      chk("reset.busy", longint'(bus.busy), 0);
      chk("reset.done", longint'(bus.done), 0);
      chk("reset.C_nonzero", longint'(bus.C_flat != '0), 0);

      // Reset in the middle of a mul discards it completely.
      fill(0, 0);
      drive_mats();
      bus.opcode = 3'b011; bus.matrix_size = 3'd5; bus.start = 1'b1;
      @(posedge clock);
      #1 bus.start = 1'b0;
      repeat (10) @(posedge clock);
      @(negedge clock) reset_n = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock) reset_n = 1'b1;
      chk("midrst.ready", longint'(bus.ready), 1);
      chk("midrst.busy", longint'(bus.busy), 0);
      chk("midrst.done", longint'(bus.done), 0);
      chk("midrst.C_nonzero", longint'(bus.C_flat != '0), 0);
      chk("midrst.ovf", longint'(bus.overflow_flag), 0);
      chk("midrst.err", longint'(bus.error_flag), 0);
      dcnt = 0;
      repeat (140) begin @(posedge clock); #1 dcnt += int'(bus.done); end
      chk("midrst.no_done", dcnt, 0);

      // Start coincident with reset is dropped.
      @(negedge clock);
      reset_n = 1'b0; bus.opcode = 3'b001; bus.matrix_size = 3'd2; bus.start = 1'b1;
      @(posedge clock);
      #1 bus.start = 1'b0;
      @(negedge clock) reset_n = 1'b1;
      @(posedge clock);
      #1;
      chk("rststart.busy", longint'(bus.busy), 0);
      chk("rststart.ready", longint'(bus.ready), 1);

      fill(1, 0);
      am[0][0] = 1;  am[0][1] = 2;  am[1][0] = 3;  am[1][1] = 4;
      bm[0][0] = 10; bm[0][1] = 20; bm[1][0] = 30; bm[1][1] = 40;
      do_op("sum2", 1, 2, 0, 0);

      fill(1, 0);
      am[0][0] = 127; bm[0][0] = 1;
      do_op("sum_ovf", 1, 1, 0, 0);

      fill(2, 0);
      am[0][0] = 1; am[0][1] = 2; am[0][2] = 3;
      am[1][0] = 4; am[1][1] = 5; am[1][2] = 6;
      am[2][0] = 7; am[2][1] = 8; am[2][2] = 9;
      do_op("mul_ident", 3, 3, 0, 0);
      fill(1, 1);
      for (int r = 0; r < DIM; r++) for (int c = 0; c < DIM; c++) am[r][c] = 50;
      do_op("mul_wrap", 3, 3, 0, 0);

      fill(2, 0);
      do_op("trans5", 5, 5, 0, 1);

      fill(0, 0);
      do_op("err_op0", 0, 2, 0, 0);
      do_op("err_n0", 1, 0, 0, 0);
      do_op("err_n6", 1, 6, 0, 0);
      fill(1, 0);
      am[0][0] = -128;
      do_op("opp_min", 4, 1, 0, 0);

      for (int t = 0; t < 40; t++) begin
         fill(0, 0);
         op = $urandom_range(0, 7);
         n  = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) + 1 - 1 - ($urandom_range(0, 1) * 5) : $urandom_range(1, 5);
         do_op($sformatf("rand%0d_op%0d_n%0d", t, op, n), op, n, $urandom_range(0, 255) - 128, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
